csi2_packet_parser: RTL and testbench
=====================================

# csi2_packet_parser

Parametrised CSI-2 packet-layer parser for the camera receive path. It sits between the lane merger and the pixel unpacker, on the parallel byte clock. It takes the lane-merged HS byte stream, assembles and ECC-checks packet headers, and tracks frame state independently for up to four virtual channels. It strips headers and CRC, and delivers byte-enabled payload beats with per-VC frame/line event pulses and error flags.

## Interface
- G_LANE_WIDTH, 4: bytes per beat; legal values 1, 2, 4.
- G_NO_OF_VC, 1: number of tracked virtual channels, 1–4. Packets with VC ≥ G_NO_OF_VC are dropped.
- G_DT_FILTER, 8'h00: long-packet data type accepted; 8'h00 accepts every long DT ≥ 0x10.

Ports:
- PARALLEL_CLOCK_I  in  1  sole clock; all logic is rising-edge.
- RESET_I  in  1  asynchronous, active-high reset.
- DATA_I  in  8*G_LANE_WIDTH  merged HS bytes; lane-0 byte in bits [7:0] is the earliest byte.
- VALID_I  in  1  high from the first header beat through EoT. A gap of at least 1 cycle low separates packets.
- PAYLOAD_O  out  8*G_LANE_WIDTH  payload bytes.
- PAYLOAD_BE_O  out  G_LANE_WIDTH  per-byte enable.
- PAYLOAD_VALID_O  out  1  payload beat strobe.
- PAYLOAD_LAST_O  out  1  final payload beat of the packet.
- VC_O  out  2  VC of the current/last decoded packet.
- DT_O  out  6  data type of the current/last decoded packet.
- WORD_COUNT_O  out  16  WC field of the current/last decoded packet.
- FRAME_VALID_O  out  G_NO_OF_VC  per-VC frame-active level.
- FRAME_START_O, FRAME_END_O, LINE_START_O, LINE_END_O  out  1 each  one-cycle pulses, qualified by VC_O.
- ECC_ERROR_O, PROTOCOL_ERROR_O, TRUNC_ERROR_O  out  1 each  one-cycle error pulses.

## Operation
- States are IDLE, HEADER, PAYLOAD and WAIT_EOT.
- IDLE → HEADER on VALID_I=1. The header is 4 bytes: DI, WC_LSB, WC_MSB, ECC. It occupies 4/G_LANE_WIDTH beats, so the header beat count is 0 in the G_LANE_WIDTH=4 case, where the first beat completes the header.
- Header complete: compute the CSI-2 6-bit Hamming ECC over the 24 bits {WC_MSB, WC_LSB, DI} and compare with ECC[5:0].
  - Mismatch: pulse ECC_ERROR_O, drop the packet, go to WAIT_EOT.
- VC = DI[7:6] and DT = DI[5:0]. If VC ≥ G_NO_OF_VC, drop the packet silently and go to WAIT_EOT.
- Short packets, DT 0x00–0x0F, go to WAIT_EOT:
  - 0x00 FS: set FRAME_VALID_O[vc] and pulse FRAME_START_O. If the bit was already set, also pulse PROTOCOL_ERROR_O; the frame restarts.
  - 0x01 FE: clear the bit and pulse FRAME_END_O. If the bit was clear, pulse PROTOCOL_ERROR_O only.
  - 0x02 LS / 0x03 LE: pulse LINE_START_O / LINE_END_O.
  - Other short DTs are ignored.
- Long packets, DT ≥ 0x10, are accepted if FRAME_VALID_O[vc]=1 and the DT passes G_DT_FILTER.
  - Frame inactive: pulse PROTOCOL_ERROR_O and drop.
  - DT filtered: drop silently.
  - Accepted with WC=0: go to WAIT_EOT with no payload beat.
  - Otherwise go to PAYLOAD and load the 16-bit remaining counter with WC.
- PAYLOAD: each VALID_I beat is forwarded. When remaining ≥ G_LANE_WIDTH, all BE bits are set and remaining decreases by G_LANE_WIDTH.
- Final beat: when remaining ≤ G_LANE_WIDTH, BE = low `remaining` bits set and LAST=1; go to WAIT_EOT.
- CRC bytes and padding are discarded in WAIT_EOT. WAIT_EOT → IDLE when VALID_I=0.
- VALID_I=0 in HEADER: return to IDLE with no error.
- VALID_I=0 in PAYLOAD: pulse TRUNC_ERROR_O, no LAST, return to IDLE.
- VC_O, DT_O and WORD_COUNT_O update at header completion for every ECC-clean packet and hold until the next one.

## Timing
- Reset values:
  - State IDLE and counters 0.
  - PAYLOAD_O 0, PAYLOAD_BE_O 0, PAYLOAD_VALID_O 0, PAYLOAD_LAST_O 0.
  - VC_O 0, DT_O 0, WORD_COUNT_O 0, FRAME_VALID_O all 0.
  - All pulses 0.
- Reset mid-packet aborts with no error pulse. The parser resumes on the next VALID_I rising edge.
- All outputs are registered.
- Header events (frame/line pulses, ECC/protocol errors, VC_O/DT_O/WORD_COUNT_O) appear 1 cycle after the final header beat.
- Payload beat n appears 1 cycle after the corresponding input beat. Throughput is one beat per cycle with no backpressure.
- TRUNC_ERROR_O asserts 1 cycle after the cycle VALID_I is sampled low.
- FRAME_VALID_O changes on the same cycle as FRAME_START_O / FRAME_END_O.
- VALID_I held high in WAIT_EOT stays in WAIT_EOT. A new packet is only recognised after VALID_I has been low for at least 1 cycle.

## Test plan
- G_LANE_WIDTH=4, VC0: send FS, then LS, a long packet DT 0x2B with WC=10, LE, FE.
  - Expect FRAME_START_O and FRAME_VALID_O[0]=1.
  - Expect 3 payload beats with BE 1111, 1111, 0011; LAST on the third beat.
  - Expect FRAME_END_O and FRAME_VALID_O[0]=0.
- G_LANE_WIDTH=1, WC=3: header spans 4 beats; expect 3 payload beats, all BE=1, LAST on beat 3. Two trailing CRC bytes produce no output.
- Flip 1 bit of the header DI → ECC_ERROR_O pulse, no frame pulse, FRAME_VALID_O unchanged, no payload.
- G_NO_OF_VC=2: interleave FS(VC1), long packet (VC0, frame inactive), FS(VC0).
  - Expect FRAME_VALID_O=2'b10, then a PROTOCOL_ERROR_O pulse, then 2'b11.
  - Expect a VC=3 packet to be ignored entirely.
- Drop VALID_I after 2 of 4 payload beats (WC=16) → 2 beats output, TRUNC_ERROR_O pulse, no LAST; the next FS parses normally.
- Assert RESET_I in PAYLOAD → next cycle all outputs are at reset values; a subsequent FS on VC0 yields FRAME_START_O.

Source files
------------

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet-layer parser: assembles and ECC-checks packet headers, tracks
// per-VC frame state, strips header/CRC and emits byte-enabled payload beats.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a VALID_I rising edge (first header beat)
// HEADER    | collecting the remaining header beats (lane width 1 or 2)
// PAYLOAD   | forwarding payload beats, counting down remaining bytes
// WAIT_EOT  | discarding CRC/padding or a dropped packet until VALID_I falls
module csi2_packet_parser #(
  parameter int         G_LANE_WIDTH = 4,
  parameter int         G_NO_OF_VC   = 1,
  parameter logic [7:0] G_DT_FILTER  = 8'h00
) (
  input  logic                        PARALLEL_CLOCK_I,
  input  logic                        RESET_I,
  input  logic [8*G_LANE_WIDTH-1:0]   DATA_I,
  input  logic                        VALID_I,
  output logic [8*G_LANE_WIDTH-1:0]   PAYLOAD_O,
  output logic [G_LANE_WIDTH-1:0]     PAYLOAD_BE_O,
  output logic                        PAYLOAD_VALID_O,
  output logic                        PAYLOAD_LAST_O,
  output logic [1:0]                  VC_O,
  output logic [5:0]                  DT_O,
  output logic [15:0]                 WORD_COUNT_O,
  output logic [G_NO_OF_VC-1:0]       FRAME_VALID_O,
  output logic                        FRAME_START_O,
  output logic                        FRAME_END_O,
  output logic                        LINE_START_O,
  output logic                        LINE_END_O,
  output logic                        ECC_ERROR_O,
  output logic                        PROTOCOL_ERROR_O,
  output logic                        TRUNC_ERROR_O
);

  localparam int         DW         = 8 * G_LANE_WIDTH;
  localparam logic [1:0] HDR_LAST   = 2'(4 / G_LANE_WIDTH - 1);
  localparam logic [15:0] LANE_BYTES = 16'(G_LANE_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_WAIT_EOT
  } state_t;

  state_t                  state_q;
  logic [1:0]              hdr_cnt_q;
  logic [31:0]             hdr_q;
  logic [15:0]             rem_q;
  logic                    valid_prev_q;

  logic [DW-1:0]           payload_q;
  logic [G_LANE_WIDTH-1:0] payload_be_q;
  logic                    payload_valid_q;
  logic                    payload_last_q;
  logic [1:0]              vc_q;
  logic [5:0]              dt_q;
  logic [15:0]             wc_q;
  logic [G_NO_OF_VC-1:0]   frame_valid_q;
  logic                    frame_start_q;
  logic                    frame_end_q;
  logic                    line_start_q;
  logic                    line_end_q;
  logic                    ecc_error_q;
  logic                    protocol_error_q;
  logic                    trunc_error_q;

  logic [DW+31:0]          hdr_cat;
  logic [31:0]             hdr_d;
  logic [1:0]              hdr_vc;
  logic [5:0]              hdr_dt;
  logic [15:0]             hdr_wc;
  logic                    ecc_ok;
  logic                    vc_ok;
  logic                    dt_pass;
  logic                    fv_sel;
  logic                    hdr_beat;
  logic                    hdr_final;
  logic                    rem_last;
  logic [G_LANE_WIDTH-1:0] be_d;
  logic                    unused_hdr;

  // CSI-2 6-bit Hamming code over {WC_MSB, WC_LSB, DI}
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // New bytes shift in from the top so the earliest byte (DI) ends in [7:0]
  // once the last header beat arrives, for any lane width.
  assign hdr_cat    = {DATA_I, hdr_q};
  assign hdr_d      = hdr_cat[DW+31 -: 32];
  // Bytes shifted out of the window and ECC[7:6] carry no information here.
  assign unused_hdr = ^{hdr_cat[DW-1:0], hdr_d[31:30]};

  // Decode the header as it stands including the current beat
  always_comb begin
    hdr_vc   = hdr_d[7:6];
    hdr_dt   = hdr_d[5:0];
    hdr_wc   = hdr_d[23:8];
    ecc_ok   = (csi2_ecc(hdr_d[23:0]) == hdr_d[29:24]);
    vc_ok    = (int'(hdr_vc) < G_NO_OF_VC);
    dt_pass  = (G_DT_FILTER == 8'h00) || ({2'b00, hdr_dt} == G_DT_FILTER);
    fv_sel   = 1'b0;
    for (int i = 0; i < G_NO_OF_VC; i++) begin
      if (hdr_vc == 2'(i)) fv_sel = frame_valid_q[i];
    end
    hdr_beat  = VALID_I && (((state_q == S_IDLE) && !valid_prev_q) ||
                            (state_q == S_HEADER));
    hdr_final = (hdr_cnt_q == HDR_LAST);
  end

  // Byte enables and final-beat detection for the current payload beat
  always_comb begin
    be_d = '0;
    for (int i = 0; i < G_LANE_WIDTH; i++) begin
      be_d[i] = (rem_q > 16'(i));
    end
    rem_last = (rem_q <= LANE_BYTES);
  end

  // Packet FSM with registered outputs
  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      state_q          <= S_IDLE;
      hdr_cnt_q        <= '0;
      hdr_q            <= '0;
      rem_q            <= '0;
      // Starts high so a packet already in flight when reset releases is
      // ignored until VALID_I has been seen low.
      valid_prev_q     <= 1'b1;
      payload_q        <= '0;
      payload_be_q     <= '0;
      payload_valid_q  <= 1'b0;
      payload_last_q   <= 1'b0;
      vc_q             <= '0;
      dt_q             <= '0;
      wc_q             <= '0;
      frame_valid_q    <= '0;
      frame_start_q    <= 1'b0;
      frame_end_q      <= 1'b0;
      line_start_q     <= 1'b0;
      line_end_q       <= 1'b0;
      ecc_error_q      <= 1'b0;
      protocol_error_q <= 1'b0;
      trunc_error_q    <= 1'b0;
    end else begin
      valid_prev_q     <= VALID_I;
      payload_be_q     <= '0;
      payload_valid_q  <= 1'b0;
      payload_last_q   <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_end_q      <= 1'b0;
      line_start_q     <= 1'b0;
      line_end_q       <= 1'b0;
      ecc_error_q      <= 1'b0;
      protocol_error_q <= 1'b0;
      trunc_error_q    <= 1'b0;

      if (hdr_beat) begin
        hdr_q <= hdr_d;
        if (!hdr_final) begin
          hdr_cnt_q <= hdr_cnt_q + 2'd1;
          state_q   <= S_HEADER;
        end else begin
          hdr_cnt_q <= '0;
          state_q   <= S_WAIT_EOT;
          if (!ecc_ok) begin
            ecc_error_q <= 1'b1;
          end else begin
            vc_q <= hdr_vc;
            dt_q <= hdr_dt;
            wc_q <= hdr_wc;
            if (vc_ok) begin
              if (hdr_dt < 6'h10) begin
                case (hdr_dt)
                  6'h00: begin
                    frame_start_q    <= 1'b1;
                    protocol_error_q <= fv_sel;
                    for (int i = 0; i < G_NO_OF_VC; i++) begin
                      if (hdr_vc == 2'(i)) frame_valid_q[i] <= 1'b1;
                    end
                  end
                  6'h01: begin
                    if (fv_sel) begin
                      frame_end_q <= 1'b1;
                      for (int i = 0; i < G_NO_OF_VC; i++) begin
                        if (hdr_vc == 2'(i)) frame_valid_q[i] <= 1'b0;
                      end
                    end else begin
                      protocol_error_q <= 1'b1;
                    end
                  end
                  6'h02:   line_start_q <= 1'b1;
                  6'h03:   line_end_q   <= 1'b1;
                  default: ;
                endcase
              end else if (!fv_sel) begin
                protocol_error_q <= 1'b1;
              end else if (dt_pass && (hdr_wc != 16'h0000)) begin
                rem_q   <= hdr_wc;
                state_q <= S_PAYLOAD;
              end
            end
          end
        end
      end else begin
        case (state_q)
          // Only reached here with VALID_I low: header abandoned quietly.
          S_HEADER: begin
            hdr_cnt_q <= '0;
            state_q   <= S_IDLE;
          end
          S_PAYLOAD: begin
            if (!VALID_I) begin
              trunc_error_q <= 1'b1;
              rem_q         <= '0;
              state_q       <= S_IDLE;
            end else begin
              payload_q       <= DATA_I;
              payload_be_q    <= be_d;
              payload_valid_q <= 1'b1;
              if (rem_last) begin
                payload_last_q <= 1'b1;
                rem_q          <= '0;
                state_q        <= S_WAIT_EOT;
              end else begin
                rem_q <= rem_q - LANE_BYTES;
              end
            end
          end
          S_WAIT_EOT: begin
            if (!VALID_I) state_q <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign PAYLOAD_O        = payload_q;
  assign PAYLOAD_BE_O     = payload_be_q;
  assign PAYLOAD_VALID_O  = payload_valid_q;
  assign PAYLOAD_LAST_O   = payload_last_q;
  assign VC_O             = vc_q;
  assign DT_O             = dt_q;
  assign WORD_COUNT_O     = wc_q;
  assign FRAME_VALID_O    = frame_valid_q;
  assign FRAME_START_O    = frame_start_q;
  assign FRAME_END_O      = frame_end_q;
  assign LINE_START_O     = line_start_q;
  assign LINE_END_O       = line_end_q;
  assign ECC_ERROR_O      = ecc_error_q;
  assign PROTOCOL_ERROR_O = protocol_error_q;
  assign TRUNC_ERROR_O    = trunc_error_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Bench for csi2_packet_parser: a 4-lane/2-VC instance and a 1-lane/1-VC
// instance with a DT filter, each with its own expected-event queue.
module tb_csi2_packet_parser;

  typedef struct packed {
    logic        pv;
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
    logic        fs, fe, ls, le, ecc, proto, trunc;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [3:0]  fv;
  } ev_t;

  localparam logic [6:0] K_FS = 7'h40, K_FE = 7'h20, K_LS = 7'h10, K_LE = 7'h08;
  localparam logic [6:0] K_ECC = 7'h04, K_PRO = 7'h02, K_TRN = 7'h01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-lane instance
  logic        rst_a = 1'b1, va = 1'b0;
  logic [31:0] da = '0, pl_a;
  logic [3:0]  be_a;
  logic        pv_a, last_a, fs_a, fe_a, ls_a, le_a, ecc_a, pro_a, trn_a;
  logic [1:0]  vc_a, fv_a;
  logic [5:0]  dt_a;
  logic [15:0] wc_a;

  // 1-lane instance
  logic        rst_l1 = 1'b1, vb = 1'b0;
  logic [7:0]  db = '0, pl_b;
  logic [0:0]  be_b, fv_b;
  logic        pv_b, last_b, fs_b, fe_b, ls_b, le_b, ecc_b, pro_b, trn_b;
  logic [1:0]  vc_b;
  logic [5:0]  dt_b;
  logic [15:0] wc_b;

  csi2_packet_parser #(.G_LANE_WIDTH(4), .G_NO_OF_VC(2), .G_DT_FILTER(8'h00)) u_dut_a (
    .PARALLEL_CLOCK_I(clk), .RESET_I(rst_a), .DATA_I(da), .VALID_I(va),
    .PAYLOAD_O(pl_a), .PAYLOAD_BE_O(be_a), .PAYLOAD_VALID_O(pv_a), .PAYLOAD_LAST_O(last_a),
    .VC_O(vc_a), .DT_O(dt_a), .WORD_COUNT_O(wc_a), .FRAME_VALID_O(fv_a),
    .FRAME_START_O(fs_a), .FRAME_END_O(fe_a), .LINE_START_O(ls_a), .LINE_END_O(le_a),
    .ECC_ERROR_O(ecc_a), .PROTOCOL_ERROR_O(pro_a), .TRUNC_ERROR_O(trn_a)
  );

  csi2_packet_parser #(.G_LANE_WIDTH(1), .G_NO_OF_VC(1), .G_DT_FILTER(8'h2B)) u_dut_b (
    .PARALLEL_CLOCK_I(clk), .RESET_I(rst_l1), .DATA_I(db), .VALID_I(vb),
    .PAYLOAD_O(pl_b), .PAYLOAD_BE_O(be_b), .PAYLOAD_VALID_O(pv_b), .PAYLOAD_LAST_O(last_b),
    .VC_O(vc_b), .DT_O(dt_b), .WORD_COUNT_O(wc_b), .FRAME_VALID_O(fv_b),
    .FRAME_START_O(fs_b), .FRAME_END_O(fe_b), .LINE_START_O(ls_b), .LINE_END_O(le_b),
    .ECC_ERROR_O(ecc_b), .PROTOCOL_ERROR_O(pro_b), .TRUNC_ERROR_O(trn_b)
  );

  ev_t         qa[$], qb[$];
  string       na[$], nb[$];
  logic [31:0] wq[$];
  logic [7:0]  bq[$];

  function automatic ev_t mk(input logic pv, input logic [31:0] data, input logic [3:0] be,
                             input logic last, input logic [6:0] flags, input logic [1:0] vc,
                             input logic [5:0] dt, input logic [15:0] wc, input logic [3:0] fv);
    ev_t e;
    e = '0;
    e.pv = pv; e.data = data; e.be = be; e.last = last;
    {e.fs, e.fe, e.ls, e.le, e.ecc, e.proto, e.trunc} = flags;
    e.vc = vc; e.dt = dt; e.wc = wc; e.fv = fv;
    return e;
  endfunction

  // Header word {ECC, WC_MSB, WC_LSB, DI}; ECC bit k is parity over a column mask.
  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    return {2'b00, e, d};
  endfunction

  task automatic exp_a(input string n, input ev_t e);
    qa.push_back(e); na.push_back(n);
  endtask

  task automatic exp_b(input string n, input ev_t e);
    qb.push_back(e); nb.push_back(n);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic a_send();
    foreach (wq[i]) begin
      va = 1'b1; da = wq[i];
      @(posedge clk); #1;
    end
    va = 1'b0; da = '0;
    @(posedge clk); #1;
    wq.delete();
  endtask

  task automatic b_hdr(input logic [31:0] h);
    bq.push_back(h[7:0]); bq.push_back(h[15:8]);
    bq.push_back(h[23:16]); bq.push_back(h[31:24]);
  endtask

  task automatic b_send();
    foreach (bq[i]) begin
      vb = 1'b1; db = bq[i];
      @(posedge clk); #1;
    end
    vb = 1'b0; db = '0;
    @(posedge clk); #1;
    bq.delete();
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, req);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_pv"}, {31'b0, pv_a}, 32'h0);
    chk({tag, "_be"}, {28'b0, be_a}, 32'h0);
    chk({tag, "_payload"}, pl_a, 32'h0);
    chk({tag, "_vcdtwc"}, {8'b0, vc_a, dt_a, wc_a}, 32'h0);
    chk({tag, "_fv"}, {30'b0, fv_a}, 32'h0);
    chk({tag, "_pulses"}, {24'b0, last_a, fs_a, fe_a, ls_a, le_a, ecc_a, pro_a, trn_a}, 32'h0);
  endtask

  ev_t   obs_a, req_a, obs_b, req_b;
  string nm_a, nm_b;

  // Monitor for the 4-lane instance
  always @(negedge clk) begin
    if (!rst_a && (pv_a || fs_a || fe_a || ls_a || le_a || ecc_a || pro_a || trn_a)) begin
      obs_a = mk(pv_a, pv_a ? pl_a : 32'h0, pv_a ? be_a : 4'h0, last_a,
                 {fs_a, fe_a, ls_a, le_a, ecc_a, pro_a, trn_a}, vc_a, dt_a, wc_a, {2'b00, fv_a});
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL unexpected_a: got %h required no event", obs_a);
      end else begin
        req_a = qa.pop_front();
        nm_a  = na.pop_front();
        if (obs_a !== req_a) begin
          errors++;
          $display("FAIL %s: got %h required %h", nm_a, obs_a, req_a);
        end
      end
    end
  end

  // Monitor for the 1-lane instance
  always @(negedge clk) begin
    if (!rst_l1 && (pv_b || fs_b || fe_b || ls_b || le_b || ecc_b || pro_b || trn_b)) begin
      obs_b = mk(pv_b, pv_b ? {24'b0, pl_b} : 32'h0, pv_b ? {3'b0, be_b} : 4'h0, last_b,
                 {fs_b, fe_b, ls_b, le_b, ecc_b, pro_b, trn_b}, vc_b, dt_b, wc_b, {3'b000, fv_b});
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_b: got %h required no event", obs_b);
      end else begin
        req_b = qb.pop_front();
        nm_b  = nb.pop_front();
        if (obs_b !== req_b) begin
          errors++;
          $display("FAIL %s: got %h required %h", nm_b, obs_b, req_b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    rst_a = 1'b0; rst_l1 = 1'b0;
    chk_reset_a("reset");
    chk("reset_b_fv", {31'b0, fv_b}, 32'h0);
    idle(2);

    // Frame on VC0: FS, LS, long DT 0x2B WC=10, LE, corrupted FE, FE
    exp_a("fs_vc0", mk(0, 0, 0, 0, K_FS, 2'd0, 6'h00, 16'h0001, 4'b0001));
    wq.push_back(hdr(8'h00, 16'h0001)); a_send();
    exp_a("ls_vc0", mk(0, 0, 0, 0, K_LS, 2'd0, 6'h02, 16'h0000, 4'b0001));
    wq.push_back(hdr(8'h02, 16'h0000)); a_send();
    exp_a("pay_wc10_b0", mk(1, 32'h44332211, 4'hF, 0, 7'h0, 2'd0, 6'h2B, 16'd10, 4'b0001));
    exp_a("pay_wc10_b1", mk(1, 32'h88776655, 4'hF, 0, 7'h0, 2'd0, 6'h2B, 16'd10, 4'b0001));
    exp_a("pay_wc10_b2", mk(1, 32'hC1C0AA99, 4'h3, 1, 7'h0, 2'd0, 6'h2B, 16'd10, 4'b0001));
    wq.push_back(hdr(8'h2B, 16'd10)); wq.push_back(32'h44332211);
    wq.push_back(32'h88776655); wq.push_back(32'hC1C0AA99); wq.push_back(32'hDEADBEEF);
    a_send();
    exp_a("le_vc0", mk(0, 0, 0, 0, K_LE, 2'd0, 6'h03, 16'h0000, 4'b0001));
    wq.push_back(hdr(8'h03, 16'h0000)); a_send();
    exp_a("ecc_err", mk(0, 0, 0, 0, K_ECC, 2'd0, 6'h03, 16'h0000, 4'b0001));
    wq.push_back(hdr(8'h01, 16'h0001) ^ 32'h1); wq.push_back(32'h11111111);
    wq.push_back(32'h22222222); a_send();
    exp_a("fe_vc0", mk(0, 0, 0, 0, K_FE, 2'd0, 6'h01, 16'h0001, 4'b0000));
    wq.push_back(hdr(8'h01, 16'h0001)); a_send();

    // Two virtual channels interleaved, plus an untracked VC3
    exp_a("fs_vc1", mk(0, 0, 0, 0, K_FS, 2'd1, 6'h00, 16'h0002, 4'b0010));
    wq.push_back(hdr(8'h40, 16'h0002)); a_send();
    exp_a("long_no_frame", mk(0, 0, 0, 0, K_PRO, 2'd0, 6'h2B, 16'h0004, 4'b0010));
    wq.push_back(hdr(8'h2B, 16'h0004)); wq.push_back(32'h04030201); wq.push_back(32'h0000C1C0);
    a_send();
    exp_a("fs_vc0_b", mk(0, 0, 0, 0, K_FS, 2'd0, 6'h00, 16'h0003, 4'b0011));
    wq.push_back(hdr(8'h00, 16'h0003)); a_send();
    wq.push_back(hdr(8'hC0, 16'h0005)); a_send();
    wq.push_back(hdr(8'hEB, 16'h0004)); wq.push_back(32'h55555555); wq.push_back(32'h0000AAAA);
    a_send();
    wq.push_back(hdr(8'h08, 16'h0000)); a_send();
    exp_a("fs_vc1_dup", mk(0, 0, 0, 0, K_FS | K_PRO, 2'd1, 6'h00, 16'h0002, 4'b0011));
    wq.push_back(hdr(8'h40, 16'h0002)); a_send();
    exp_a("fe_vc1", mk(0, 0, 0, 0, K_FE, 2'd1, 6'h01, 16'h0002, 4'b0001));
    wq.push_back(hdr(8'h41, 16'h0002)); a_send();
    exp_a("fe_vc1_dup", mk(0, 0, 0, 0, K_PRO, 2'd1, 6'h01, 16'h0002, 4'b0001));
    wq.push_back(hdr(8'h41, 16'h0002)); a_send();

    // WC=0 long packet gives nothing; WC=4 gives one full final beat
    wq.push_back(hdr(8'h2B, 16'h0000)); wq.push_back(32'h0000C5C4); a_send();
    exp_a("pay_wc4", mk(1, 32'h0D0C0B0A, 4'hF, 1, 7'h0, 2'd0, 6'h2B, 16'd4, 4'b0001));
    wq.push_back(hdr(8'h2B, 16'd4)); wq.push_back(32'h0D0C0B0A); wq.push_back(32'h0000C3C2);
    a_send();

    // Truncated WC=16 packet after two beats
    exp_a("pay_tr_b0", mk(1, 32'h13121110, 4'hF, 0, 7'h0, 2'd0, 6'h2B, 16'd16, 4'b0001));
    exp_a("pay_tr_b1", mk(1, 32'h17161514, 4'hF, 0, 7'h0, 2'd0, 6'h2B, 16'd16, 4'b0001));
    exp_a("trunc", mk(0, 0, 0, 0, K_TRN, 2'd0, 6'h2B, 16'd16, 4'b0001));
    wq.push_back(hdr(8'h2B, 16'd16)); wq.push_back(32'h13121110); wq.push_back(32'h17161514);
    a_send();
    exp_a("fe_after_trunc", mk(0, 0, 0, 0, K_FE, 2'd0, 6'h01, 16'h0003, 4'b0000));
    wq.push_back(hdr(8'h01, 16'h0003)); a_send();
    exp_a("fs_after_trunc", mk(0, 0, 0, 0, K_FS, 2'd0, 6'h00, 16'h0004, 4'b0001));
    wq.push_back(hdr(8'h00, 16'h0004)); a_send();

    // Reset while in PAYLOAD
    exp_a("pay_pre_reset", mk(1, 32'h23222120, 4'hF, 0, 7'h0, 2'd0, 6'h2B, 16'd16, 4'b0001));
    va = 1'b1; da = hdr(8'h2B, 16'd16);
    @(posedge clk); #1;
    da = 32'h23222120;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst_a = 1'b1;
    #1;
    chk_reset_a("mid_reset");
    @(posedge clk); #1;
    va = 1'b0; da = '0; rst_a = 1'b0;
    idle(2);
    exp_a("fs_post_reset", mk(0, 0, 0, 0, K_FS, 2'd0, 6'h00, 16'h0007, 4'b0001));
    wq.push_back(hdr(8'h00, 16'h0007)); a_send();

    // Single-lane instance
    exp_b("b_fs", mk(0, 0, 0, 0, K_FS, 2'd0, 6'h00, 16'h0001, 4'b0001));
    b_hdr(hdr(8'h00, 16'h0001)); b_send();
    exp_b("b_pay0", mk(1, 32'h000000A1, 4'h1, 0, 7'h0, 2'd0, 6'h2B, 16'd3, 4'b0001));
    exp_b("b_pay1", mk(1, 32'h000000A2, 4'h1, 0, 7'h0, 2'd0, 6'h2B, 16'd3, 4'b0001));
    exp_b("b_pay2", mk(1, 32'h000000A3, 4'h1, 1, 7'h0, 2'd0, 6'h2B, 16'd3, 4'b0001));
    b_hdr(hdr(8'h2B, 16'd3));
    bq.push_back(8'hA1); bq.push_back(8'hA2); bq.push_back(8'hA3);
    bq.push_back(8'hC0); bq.push_back(8'hC1);
    b_send();
    bq.push_back(8'h2B); bq.push_back(8'h03); b_send();
    b_hdr(hdr(8'h2A, 16'd2));
    bq.push_back(8'hB1); bq.push_back(8'hB2); bq.push_back(8'hC0); bq.push_back(8'hC1);
    b_send();
    exp_b("b_fe", mk(0, 0, 0, 0, K_FE, 2'd0, 6'h01, 16'h0001, 4'b0000));
    b_hdr(hdr(8'h01, 16'h0001)); b_send();

    idle(4);
    chk("a_events_left", qa.size(), 32'd0);
    chk("b_events_left", qb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
